// File: rtl/tiny_mmio_gpio.sv
// tiny_mmio_gpio: CPU bus bridge with an LED/SW/KEY register window in front of RAM.
// Define MMIO_TIMER_EN to add the 32-bit free-running cycle timer at offset 0x10.
module tiny_mmio_gpio #(
  parameter logic [31:0] IO_BASE = 32'h4000_0000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_mem_valid,
  input  logic        s_mem_we,
  input  logic [31:0] s_mem_addr,
  input  logic [31:0] s_mem_wdata,
  input  logic [3:0]  s_mem_wstrb,
  output logic        s_mem_ready,
  output logic [31:0] s_mem_rdata,
  output logic        m_mem_valid,
  output logic        m_mem_we,
  output logic [31:0] m_mem_addr,
  output logic [31:0] m_mem_wdata,
  output logic [3:0]  m_mem_wstrb,
  input  logic        m_mem_ready,
  input  logic [31:0] m_mem_rdata,
  input  logic [1:0]  key_n,
  input  logic [3:0]  sw,
  output logic [7:0]  led
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    RESP
  } state_t;

  state_t      state;
  logic        io_hit;
  logic        accept;
  logic        wr;
  logic [9:0]  ofs;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;
  logic [7:0]  led_q;
  logic [3:0]  sw_s1;
  logic [3:0]  sw_s2;
  logic [1:0]  key_s1;
  logic [1:0]  key_s2;
  logic [1:0]  key_stb;
  logic [1:0]  key_rise;
  logic [1:0]  edge_q;
  logic [1:0]  edge_clr;
  logic [31:0] timer_rd;
  logic        unused_bits;

  assign io_hit = s_mem_addr[31:12] == IO_BASE[31:12];
  assign ofs    = s_mem_addr[11:2];
  assign accept = (state == IDLE) && s_mem_valid && io_hit;
  assign wr     = accept && s_mem_we;

  assign m_mem_valid = s_mem_valid && !io_hit;
  assign m_mem_we    = s_mem_we;
  assign m_mem_addr  = s_mem_addr;
  assign m_mem_wdata = s_mem_wdata;
  assign m_mem_wstrb = s_mem_wstrb;
  assign s_mem_ready = io_hit ? ready_q : m_mem_ready;
  assign s_mem_rdata = io_hit ? rdata_q : m_mem_rdata;
  assign led         = led_q;

  assign unused_bits = ^{s_mem_addr[1:0], s_mem_wdata[31:8]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1  <= '0;
      sw_s2  <= '0;
      key_s1 <= '0;
      key_s2 <= '0;
    end else begin
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
      key_s1 <= ~key_n;
      key_s2 <= key_s1;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_db
    logic [CW-1:0] cnt;
    logic          stb;
    logic          flip;

    // flip marks the edge on which the synced level is finally accepted
    assign flip = (key_s2[k] != stb) && (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
        stb <= 1'b0;
      end else if (key_s2[k] == stb) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stb <= key_s2[k];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign key_stb[k]  = stb;
    assign key_rise[k] = flip && key_s2[k];
  end

  assign edge_clr = (wr && s_mem_wstrb[0] && ofs == 10'd3)
                  ? s_mem_wdata[1:0] : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_q <= '0;
      led_q  <= '0;
    end else begin
      edge_q <= (edge_q & ~edge_clr) | key_rise;
      if (wr && s_mem_wstrb[0] && ofs == 10'd0)
        led_q <= s_mem_wdata[7:0];
    end
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (wr && ofs == 10'd4) begin
      for (int b = 0; b < 4; b++) begin
        if (s_mem_wstrb[b])
          timer_q[8*b +: 8] <= s_mem_wdata[8*b +: 8];
      end
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  assign timer_rd = timer_q;
`else
  assign timer_rd = '0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (ofs)
      10'd0:   rd_mux = {24'h0, led_q};
      10'd1:   rd_mux = {28'h0, sw_s2};
      10'd2:   rd_mux = {30'h0, key_stb};
      10'd3:   rd_mux = {30'h0, edge_q};
      10'd4:   rd_mux = timer_rd;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            state   <= RESP;
            ready_q <= 1'b1;
            rdata_q <= rd_mux;
          end
        end
        RESP: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
